// File: rtl/y86_pkg.sv
// Shared definitions for the sequential Y86-64 core: icodes, status codes,
// controller states and the memory-instruction predicate.
package y86_pkg;

  typedef enum logic [3:0] {
    I_HALT   = 4'd0,
    I_NOP    = 4'd1,
    I_RRMOVQ = 4'd2,
    I_IRMOVQ = 4'd3,
    I_RMMOVQ = 4'd4,
    I_MRMOVQ = 4'd5,
    I_OPQ    = 4'd6,
    I_JXX    = 4'd7,
    I_CALL   = 4'd8,
    I_RET    = 4'd9,
    I_PUSHQ  = 4'd10,
    I_POPQ   = 4'd11
  } icode_t;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPDATE,
    S_HALT
  } state_t;

  // Instructions that touch data memory and may therefore stall in MEMORY.
  function automatic logic is_mem_icode(input logic [3:0] ic);
    case (ic)
      I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: return 1'b1;
      default:                                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready data-memory cycles; expire flags that the
// current not-ready cycle is the LIMIT-th one.
module mem_wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expire
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (clear) begin
      wait_cnt <= '0;
    end else if (count && (wait_cnt != W'(LIMIT))) begin
      wait_cnt <= wait_cnt + W'(1);
    end
  end

  // Not gated by count so the FSM can read it without a combinational loop.
  assign expire = (wait_cnt == W'(LIMIT - 1));

endmodule

// File: rtl/y86_seq_controller.sv
// Stage sequencer for the sequential Y86-64 core: one state per stage, one
// enable per stage, status tracking and saturating retire/busy counters.
//
// state       | meaning
// IDLE        | waiting for start
// FETCH       | fetch unit enabled; fault/halt checks on exit
// DECODE      | decode unit enabled
// EXECUTE     | execute unit enabled
// MEMORY      | memory unit enabled; stalls for dmem_ready on memory icodes
// WRITEBACK   | writeback unit enabled
// PCUPDATE    | PC-update unit enabled; instruction retires
// HALT        | stopped, stat frozen until reset
module y86_seq_controller
  import y86_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             dmem_ready,
  input  logic             dmem_error,
  output logic             en_fetch,
  output logic             en_decode,
  output logic             en_execute,
  output logic             en_memory,
  output logic             en_writeback,
  output logic             en_pcupdate,
  output logic [2:0]       stat,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state, state_nxt;
  stat_t      stat_q, stat_nxt;
  logic [3:0] icode_q;
  logic       icode_ld;
  logic       retire;
  logic       mem_count;
  logic       mem_expire;

  mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_wait (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state != S_MEMORY),
    .count  (mem_count),
    .expire (mem_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      stat_q  <= STAT_AOK;
      icode_q <= '0;
    end else begin
      state  <= state_nxt;
      stat_q <= stat_nxt;
      if (icode_ld) icode_q <= icode;
    end
  end

  always_comb begin
    state_nxt = state;
    stat_nxt  = stat_q;
    icode_ld  = 1'b0;
    retire    = 1'b0;
    mem_count = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_FETCH;
      S_FETCH: begin
        if (imem_error) begin
          state_nxt = S_HALT;
          stat_nxt  = STAT_ADR;
        end else if (!instr_valid) begin
          state_nxt = S_HALT;
          stat_nxt  = STAT_INS;
        end else if (icode == I_HALT) begin
          state_nxt = S_HALT;
          stat_nxt  = STAT_HLT;
          retire    = 1'b1;
        end else begin
          icode_ld  = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE:  state_nxt = S_EXECUTE;
      S_EXECUTE: state_nxt = S_MEMORY;
      S_MEMORY: begin
        if (!is_mem_icode(icode_q)) begin
          state_nxt = S_WRITEBACK;
        end else if (dmem_error) begin
          state_nxt = S_HALT;
          stat_nxt  = STAT_ADR;
        end else if (dmem_ready) begin
          state_nxt = S_WRITEBACK;
        end else begin
          mem_count = 1'b1;
          if (mem_expire) begin
            state_nxt = S_HALT;
            stat_nxt  = STAT_ADR;
          end
        end
      end
      S_WRITEBACK: state_nxt = S_PCUPDATE;
      S_PCUPDATE: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= '0;
      cycle_count <= '0;
    end else begin
      if (retire && (instr_count != CNT_MAX)) instr_count <= instr_count + CNT_W'(1);
      if (busy && (cycle_count != CNT_MAX))   cycle_count <= cycle_count + CNT_W'(1);
    end
  end

  assign en_fetch     = (state == S_FETCH);
  assign en_decode    = (state == S_DECODE);
  assign en_execute   = (state == S_EXECUTE);
  assign en_memory    = (state == S_MEMORY);
  assign en_writeback = (state == S_WRITEBACK);
  assign en_pcupdate  = (state == S_PCUPDATE);
  assign busy         = (state != S_IDLE) && (state != S_HALT);
  assign halted       = (state == S_HALT);
  assign stat         = stat_q;

endmodule
